// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  // Data word width of the load/store port.
  localparam int WORD_W = 32;

  // Width of the wait-state counter (supports LATENCY 0..15).
  localparam int CNT_W = 4;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read data is registered (read-before-write).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  index,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Write when enabled; always register the addressed word for reading.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
    rdata <= mem[index];
  end

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// MEM-stage target: accepts one load/store, waits LATENCY cycles, commits,
// then holds a response until the requester takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDR_W-3:0] DEPTH_LIM = (ADDR_W-2)'(DEPTH_WORDS);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  // Request fields captured at acceptance.
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [WORD_W-1:0] wdata_reg;

  // Response qualifiers captured on the edge entering RESP.
  logic rsp_err_reg;
  logic rd_sel_reg;

  logic accept, enter_resp, rsp_done;

  // With zero latency the commit happens on the acceptance edge, so the
  // live request fields are used in IDLE and the latched copies otherwise.
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_wdata;
  logic [ADDR_W-3:0] cur_word;
  logic              cur_err;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign cur_we    = (state_reg == IDLE) ? req_we    : we_reg;
  assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign cur_word  = cur_addr[ADDR_W-1:2];

  // Misaligned or beyond the array: never aliased onto a real word.
  assign cur_err = (cur_addr[1:0] != 2'b00) || (cur_word >= DEPTH_LIM);

  // Reset on the commit edge drops the store.
  assign ram_we = enter_resp && cur_we && !cur_err && !reset;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .index (cur_word[IDX_W-1:0]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    enter_resp = 1'b0;
    rsp_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          rsp_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Wait-state counter: loaded on acceptance, counts down in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= LAT_INIT;
    end else if (state_reg == WAIT && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // Capture request fields so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
    end
  end

  // Response qualifiers: set entering RESP, cleared by handshake or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_err_reg <= 1'b0;
      rd_sel_reg  <= 1'b0;
    end else if (enter_resp) begin
      rsp_err_reg <= cur_err;
      rd_sel_reg  <= !cur_we && !cur_err;
    end else if (rsp_done) begin
      rsp_err_reg <= 1'b0;
      rd_sel_reg  <= 1'b0;
    end
  end

  // The RAM keeps reading the latched index throughout RESP with no writes,
  // so its registered output stays stable while the response is held.
  assign rsp_rdata = rd_sel_reg ? ram_rdata : '0;
  assign rsp_err   = rsp_err_reg;
  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: instance 0 has LATENCY=2, instance 1 LATENCY=0.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  // Reference memory image per instance.
  logic [31:0] model [2][256];

  int n_vec;
  int n_err;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      dmem_responder #(
        .ADDR_W      (32),
        .DEPTH_WORDS (256),
        .LATENCY     ((gi == 0) ? 2 : 0)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid[gi]),
        .req_ready (req_ready[gi]),
        .req_we    (req_we[gi]),
        .req_addr  (req_addr[gi]),
        .req_wdata (req_wdata[gi]),
        .rsp_valid (rsp_valid[gi]),
        .rsp_ready (rsp_ready[gi]),
        .rsp_rdata (rsp_rdata[gi]),
        .rsp_err   (rsp_err[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction on instance d, with the response held for 'hold' cycles.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold);
    int          lat;
    int          k;
    logic        exp_err;
    logic [31:0] exp_rd;
    lat = (d == 0) ? 2 : 0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = 1'b0;
    k = 0;
    while (!req_ready[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("d%0d accept", d), {31'd0, req_ready[d]}, 32'd1);
    if (!req_ready[d]) begin
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request bus after acceptance; the responder must ignore it.
    req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;

    exp_err = (addr % 4 != 0) || (addr / 4 >= 256);
    if (we && !exp_err) model[d][addr / 4] = wdata;
    exp_rd = (we || exp_err) ? 32'd0 : model[d][addr / 4];

    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk($sformatf("d%0d wait rsp_valid", d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("d%0d wait req_ready", d), {31'd0, req_ready[d]}, 32'd0);
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
    end
    @(negedge clk);
    chk($sformatf("d%0d rsp_valid", d), {31'd0, rsp_valid[d]}, 32'd1);
    chk($sformatf("d%0d rdata a=%h", d, addr), rsp_rdata[d], exp_rd);
    chk($sformatf("d%0d err a=%h", d, addr), {31'd0, rsp_err[d]}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk($sformatf("d%0d hold valid", d), {31'd0, rsp_valid[d]}, 32'd1);
      chk($sformatf("d%0d hold rdata", d), rsp_rdata[d], exp_rd);
      chk($sformatf("d%0d hold err", d), {31'd0, rsp_err[d]}, {31'd0, exp_err});
      chk($sformatf("d%0d hold req_ready", d), {31'd0, req_ready[d]}, 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("d%0d done valid", d), {31'd0, rsp_valid[d]}, 32'd0);
    chk($sformatf("d%0d done req_ready", d), {31'd0, req_ready[d]}, 32'd1);
    chk($sformatf("d%0d done rdata", d), rsp_rdata[d], 32'd0);
    chk($sformatf("d%0d done err", d), {31'd0, rsp_err[d]}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7) return {22'd0, 8'($urandom), 2'b00};
    if (sel < 9) return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
    return 32'h400 + ($urandom & 32'h00ff_fffc);
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d reset req_ready", d), {31'd0, req_ready[d]}, 32'd1);
      chk($sformatf("d%0d reset rsp_valid", d), {31'd0, rsp_valid[d]}, 32'd0);
      chk($sformatf("d%0d reset rdata", d), rsp_rdata[d], 32'd0);
      chk($sformatf("d%0d reset err", d), {31'd0, rsp_err[d]}, 32'd0);
    end

    // Fill both memories so every later load has a known reference value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        txn(d, 1'b1, 32'(i * 4), $urandom, 0);

    // Store then load, then misaligned store and out-of-range load.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 5);
    txn(0, 1'b1, 32'h12, 32'hCAFEF00D, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 0);
    txn(0, 1'b0, 32'h400, 32'h0, 0);
    txn(1, 1'b0, 32'h3FC, 32'h0, 1);
    txn(1, 1'b0, 32'h400, 32'h0, 0);

    // Zero-latency instance: a request held during RESP waits for the handshake.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h0;
    @(posedge clk);
    #1;
    req_addr[1] = 32'h4;
    @(negedge clk);
    chk("l0 rsp_valid T+1", {31'd0, rsp_valid[1]}, 32'd1);
    chk("l0 rdata", rsp_rdata[1], model[1][0]);
    chk("l0 req_ready in RESP", {31'd0, req_ready[1]}, 32'd0);
    @(negedge clk);
    chk("l0 still held", {31'd0, rsp_valid[1]}, 32'd1);
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    chk("l0 after hs valid", {31'd0, rsp_valid[1]}, 32'd0);
    chk("l0 after hs req_ready", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("l0 b2b rsp_valid", {31'd0, rsp_valid[1]}, 32'd1);
    chk("l0 b2b rdata", rsp_rdata[1], model[1][1]);
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b0;

    // Reset one cycle after accepting a store: the store must be dropped.
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'h1234;
    chk("rst ready before", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("rst rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst rdata", rsp_rdata[0], 32'd0);
    chk("rst err", {31'd0, rsp_err[0]}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("rst no late rsp", {31'd0, rsp_valid[0]}, 32'd0);
    end
    txn(0, 1'b0, 32'h20, 32'h0, 0);

    // Randomized mix of loads and stores with random backpressure.
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < 2; d++) begin
        txn(d, 1'($urandom), rand_addr(), $urandom, $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dmem_responder
